// File: rtl/pulse_shaper_tx.sv
// Request-driven pulse generator: fixed-width high pulses separated by a minimum gap,
// with a saturating queue of pending requests. Optional done flag via PULSE_SHAPER_TX_DONE_EN.
//
// state | meaning
// IDLE  | no pulse in progress, pulse_out low
// HIGH  | pulse_out high for HIGH_CYC cycles
// GAP   | pulse_out low for GAP_CYC cycles before the next pulse may start
module pulse_shaper_tx #(
   parameter int unsigned HIGH_CYC = 4,
   parameter int unsigned GAP_CYC  = 4,
   parameter int unsigned PEND_W   = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req,
   output logic              pulse_out,
   output logic              busy,
   output logic [PEND_W-1:0] pend_cnt,
   output logic              overflow
`ifdef PULSE_SHAPER_TX_DONE_EN
   ,
   output logic              done
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HIGH = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   localparam logic [7:0]        HIGH_LD  = 8'(HIGH_CYC - 1);
   localparam logic [7:0]        GAP_LD   = 8'(GAP_CYC - 1);
   localparam logic [PEND_W-1:0] PEND_MAX = '1;

   state_t            state_q, state_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [PEND_W-1:0] pend_q, pend_d;
   logic              pulse_q, pulse_d;
   logic              busy_q, busy_d;
   logic              ovf_q, ovf_d;
   logic              gap_end;
   logic              pend_inc;
   logic              pend_dec;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      pend_d   = pend_q;
      ovf_d    = 1'b0;
      gap_end  = (state_q == ST_GAP) && (cnt_q == 8'd0);
      pend_dec = gap_end && (pend_q != '0);
      // A request on the last gap cycle with an empty queue launches the pulse directly.
      pend_inc = req && (state_q != ST_IDLE) && !(gap_end && (pend_q == '0));

      case (state_q)
         ST_IDLE: begin
            if (req) begin
               state_d = ST_HIGH;
               cnt_d   = HIGH_LD;
            end
         end
         ST_HIGH: begin
            if (cnt_q == 8'd0) begin
               state_d = ST_GAP;
               cnt_d   = GAP_LD;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         ST_GAP: begin
            if (cnt_q == 8'd0) begin
               if ((pend_q != '0) || req) begin
                  state_d = ST_HIGH;
                  cnt_d   = HIGH_LD;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 8'd0;
         end
      endcase

      if (pend_inc && !pend_dec) begin
         if (pend_q == PEND_MAX) begin
            ovf_d = 1'b1;
         end else begin
            pend_d = pend_q + PEND_W'(1);
         end
      end else if (pend_dec && !pend_inc) begin
         pend_d = pend_q - PEND_W'(1);
      end

      pulse_d = (state_d == ST_HIGH);
      busy_d  = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= 8'd0;
         pend_q  <= '0;
         pulse_q <= 1'b0;
         busy_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         pulse_q <= pulse_d;
         busy_q  <= busy_d;
         ovf_q   <= ovf_d;
      end
   end

   assign pulse_out = pulse_q;
   assign busy      = busy_q;
   assign pend_cnt  = pend_q;
   assign overflow  = ovf_q;

`ifdef PULSE_SHAPER_TX_DONE_EN
   logic done_q, done_d;

   // High during the final gap cycle, i.e. set by the edge that completes the gap countdown.
   always_comb begin
      done_d = (state_d == ST_GAP) && (cnt_d == 8'd0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_q <= 1'b0;
      end else begin
         done_q <= done_d;
      end
   end

   assign done = done_q;
`endif

endmodule

// File: doc/pulse_shaper_tx.md
PULSE_SHAPER_TX -- requirements
Module: pulse_shaper_tx

Interface
REQ-001 SHALL have parameter HIGH_CYC, default 4: pulse_out high width in clk cycles; valid range 1..255; default exceeds the 3-cycle glitch window of the team's receive-side high-glitch filter.
REQ-002 SHALL have parameter GAP_CYC, default 4: minimum low time between pulses in clk cycles; valid range 1..255.
REQ-003 SHALL have parameter PEND_W, default 3: width of the pending-request counter.
REQ-004 SHALL have clk, input, 1 bit: clock; all state changes on the rising edge.
REQ-005 SHALL have rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have req, input, 1 bit: pulse request; each sampled-high cycle is one request.
REQ-007 SHALL have pulse_out, output, 1 bit: shaped pulse, driven directly from a register.
REQ-008 SHALL have busy, output, 1 bit: high when state is not IDLE.
REQ-009 SHALL have pend_cnt, output, PEND_W bits: number of queued requests not yet started.
REQ-010 SHALL have overflow, output, 1 bit: one-cycle flag for a dropped request.

Function
REQ-011 SHALL implement three states: IDLE, HIGH, GAP.
REQ-012 In IDLE, req=1 at edge k SHALL move the FSM to HIGH and set pulse_out=1 at edge k (1-cycle latency); pend_cnt SHALL be unchanged.
REQ-013 HIGH SHALL last exactly HIGH_CYC cycles with pulse_out=1, then move to GAP with pulse_out=0.
REQ-014 GAP SHALL last exactly GAP_CYC cycles with pulse_out=0.
REQ-015 At the end of GAP, the FSM SHALL go to HIGH and decrement pend_cnt if pend_cnt>0; otherwise it SHALL go to IDLE.
REQ-016 req=1 in HIGH or GAP SHALL increment pend_cnt.
REQ-017 req=1 on the final GAP cycle with pend_cnt>0 SHALL leave pend_cnt unchanged, because the increment and decrement cancel; the next pulse SHALL start.
REQ-018 req=1 on the final GAP cycle with pend_cnt=0 SHALL start the next pulse immediately with no IDLE cycle; pend_cnt SHALL stay 0.
REQ-019 pend_cnt SHALL saturate at 2^PEND_W-1; req at saturation, without a same-cycle decrement, SHALL be dropped and overflow SHALL be 1 for exactly one cycle.
REQ-020 The HIGH/GAP down-counter SHALL be 8 bits wide and SHALL not wrap; values are loaded with HIGH_CYC-1 or GAP_CYC-1.
REQ-021 busy SHALL be registered and equal to (next state != IDLE).

Reset
REQ-022 rst_n=0 SHALL immediately force state IDLE, pulse_out=0, busy=0, pend_cnt=0, overflow=0, and clear the down-counter, regardless of clk.
REQ-023 Reset mid-HIGH SHALL truncate the pulse; after release no pulse SHALL occur until a new req.
REQ-024 The first edge after rst_n deasserts SHALL sample req normally.

Configuration
REQ-025 With macro PULSE_SHAPER_TX_DONE_EN defined, the block SHALL add output done (1 bit, reset 0), asserted for exactly one cycle at the edge where each GAP phase completes.
REQ-026 Without PULSE_SHAPER_TX_DONE_EN, the done port and its logic SHALL be absent; all other behaviour is identical.

Verification
(All scenarios use HIGH_CYC=4, GAP_CYC=4, PEND_W=3.)
REQ-027 Single req sampled at edge 10 -> pulse_out=1 after edges 10-13 and 0 after edges 14-17; busy=0 after edge 18; pend_cnt stays 0.
REQ-028 req high for 3 consecutive edges 10-12 -> pend_cnt=2 after edge 12; three 4-high/4-low pulses back to back; pend_cnt=0 after the third pulse starts at edge 26.
REQ-029 req high for 9 consecutive edges -> pend_cnt saturates at 7; overflow=1 for one cycle on the 9th req; exactly 8 pulses emitted.
REQ-030 pend_cnt=1 and req on the final GAP cycle -> next pulse starts with no idle cycle; pend_cnt remains 1.
REQ-031 rst_n low 2 cycles into HIGH -> pulse_out=0 without a clock edge; pend_cnt=0; no pulse after release until a new req.
REQ-032 With PULSE_SHAPER_TX_DONE_EN defined, a single req at edge 10 -> done=1 after edge 17 only.
